envelope_vca: RTL and testbench

ADSR envelope generator and voltage-controlled amplifier sitting directly downstream of `oscillator`. It takes the oscillator's free-running amplitude word `v` and a key gate, runs an attack/decay/sustain/release level machine at a divided tick rate, and scales the waveform about its midpoint by the current level. Its output feeds the DAC/PWM output stage.

---
 rtl/envelope_vca.sv | 179 +++++++++++++++++
 tb/tb_envelope_vca.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// envelope_vca: ADSR envelope generator plus VCA placed after the oscillator.
// The envelope level advances once per TICK_DIV clocks. The oscillator word
// is scaled about its midpoint by the top byte of that level, through a
// two-stage pipeline.
// Optional build macro: ENV_EXP_RELEASE_EN selects an exponential release
// tail, (level >> release_rate[3:0]) + 1. When it is undefined the release
// is linear and steps down by release_rate on each tick.
`ifndef OSC_DEPTH
`define OSC_DEPTH 12
`endif

module envelope_vca #(
    parameter int TICK_DIV = 2500,
    parameter int DEPTH    = `OSC_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate,
    input  logic [DEPTH-1:0] v_in,
    input  logic [7:0]       attack_step,
    input  logic [7:0]       decay_step,
    input  logic [7:0]       sustain_level,
    input  logic [7:0]       release_rate,
    output logic [DEPTH-1:0] v_out,
    output logic [15:0]      env_level,
    output logic             busy
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW    = DEPTH + 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } state_t;

    logic [CNT_W-1:0]     r_tick_cnt;
    logic                 w_tick;
    logic                 r_gate_q;
    logic                 w_rise;
    logic                 w_fall;
    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_level;
    logic [15:0]          w_level_next;
    logic [15:0]          w_target;
    logic [16:0]          w_att_sum;
    logic [16:0]          w_dec_diff;
    logic [16:0]          w_rel_dec;
    logic [16:0]          w_rel_diff;

    logic signed [DEPTH:0] w_s;
    logic signed [PW-1:0]  w_s_ext;
    logic signed [PW-1:0]  w_gain;
    logic signed [PW-1:0]  w_p;
    logic signed [PW-1:0]  r_prod;
    logic [DEPTH-1:0]      w_scaled;
    logic [DEPTH-1:0]      r_v_out;

    assign w_tick   = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
    assign w_rise   = gate & ~r_gate_q;
    assign w_fall   = ~gate & r_gate_q;
    assign w_target = {sustain_level, sustain_level};

    // A 17-bit sum and differences, so overflow and underflow show up in bit 16.
    assign w_att_sum  = {1'b0, r_level} + {9'b0, attack_step};
    assign w_dec_diff = {1'b0, r_level} - {9'b0, decay_step};
`ifdef ENV_EXP_RELEASE_EN
    assign w_rel_dec  = {1'b0, r_level >> release_rate[3:0]} + 17'd1;
`else
    assign w_rel_dec  = {9'b0, release_rate};
`endif
    assign w_rel_diff = {1'b0, r_level} - w_rel_dec;

    // Free-running envelope tick divider; gate activity never restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    // Register the key gate once for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_q <= 1'b0;
        end else begin
            r_gate_q <= gate;
        end
    end

    // Envelope state and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_level <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
        end
    end

    // Next state and level. A gate edge that changes state takes priority
    // over a coincident tick, and the level is held in that case.
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        if (w_rise && (r_state == ST_IDLE || r_state == ST_RELEASE)) begin
            w_state_next = ST_ATTACK;
        end else if (w_fall && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                                r_state == ST_SUSTAIN)) begin
            w_state_next = ST_RELEASE;
        end else if (w_tick) begin
            case (r_state)
                ST_ATTACK: begin
                    if (attack_step == 8'd0 || w_att_sum >= 17'h0FFFF) begin
                        w_level_next = 16'hFFFF;
                        w_state_next = ST_DECAY;
                    end else begin
                        w_level_next = w_att_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_step == 8'd0 || w_dec_diff[16] ||
                        w_dec_diff[15:0] <= w_target) begin
                        w_level_next = w_target;
                        w_state_next = ST_SUSTAIN;
                    end else begin
                        w_level_next = w_dec_diff[15:0];
                    end
                end
                ST_SUSTAIN: begin
                    w_level_next = w_target;
                end
                ST_RELEASE: begin
                    if (release_rate == 8'd0 || w_rel_diff[16] ||
                        w_rel_diff[15:0] == 16'd0) begin
                        w_level_next = 16'd0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_level_next = w_rel_diff[15:0];
                    end
                end
                default: begin
                    w_level_next = r_level;
                end
            endcase
        end
    end

    // Offset-binary to two's complement: invert the MSB and sign-extend.
    assign w_s      = $signed({~v_in[DEPTH-1], ~v_in[DEPTH-1], v_in[DEPTH-2:0]});
    assign w_s_ext  = PW'(w_s);
    assign w_gain   = $signed(PW'({1'b0, r_level[15:8]}));
    assign w_p      = w_s_ext * w_gain;
    assign w_scaled = DEPTH'(r_prod >>> 8);

    // VCA pipeline. Stage 1 holds the signed product. Stage 2 holds the
    // re-centred output, converted back to offset binary by inverting the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod  <= '0;
            r_v_out <= {1'b1, {(DEPTH-1){1'b0}}};
        end else begin
            r_prod  <= w_p;
            r_v_out <= {~w_scaled[DEPTH-1], w_scaled[DEPTH-2:0]};
        end
    end

    assign v_out     = r_v_out;
    assign env_level = r_level;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_envelope_vca.sv
// Testbench for envelope_vca.
// A cycle-level behavioural model built from the ADSR rules, using plain
// integer arithmetic, is compared against the DUT on every cycle.
// Hand-written sequences and a VCA vector table are checked against
// constant expected values.
`timescale 1ns/1ps

module tb_envelope_vca;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 12;
    localparam int MID      = 2048;
    localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic             clk           = 1'b0;
    logic             rst_n         = 1'b0;
    logic             gate          = 1'b0;
    logic [DEPTH-1:0] v_in          = 12'd2048;
    logic [7:0]       attack_step   = 8'd0;
    logic [7:0]       decay_step    = 8'd0;
    logic [7:0]       sustain_level = 8'd0;
    logic [7:0]       release_rate  = 8'd0;
    logic [DEPTH-1:0] v_out;
    logic [15:0]      env_level;
    logic             busy;

    int total = 0;
    int bad   = 0;

    envelope_vca #(.TICK_DIV(TICK_DIV), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate         (gate),
        .v_in         (v_in),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .v_out        (v_out),
        .env_level    (env_level),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int st;
        int lvl;
    } env_t;

    env_t m_env  = '{M_IDLE, 0};
    int   m_cnt  = 0;
    bit   m_gq   = 1'b0;
    int   m_prod = 0;
    int   m_vout = MID;
    bit   m_on   = 1'b0;

    function automatic int fdiv256(int x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    function automatic env_t env_next(env_t cur, bit tick, bit g, bit gq,
                                      int a, int d, int s, int r);
        env_t n;
        int   tgt;
        int   dec;
        n   = cur;
        tgt = s * 257;
        if (g && !gq && (cur.st == M_IDLE || cur.st == M_REL)) begin
            n.st = M_ATT;
        end else if (!g && gq && (cur.st == M_ATT || cur.st == M_DEC || cur.st == M_SUS)) begin
            n.st = M_REL;
        end else if (tick) begin
            if (cur.st == M_ATT) begin
                if (a == 0 || cur.lvl + a >= 65535) begin
                    n.lvl = 65535; n.st = M_DEC;
                end else n.lvl = cur.lvl + a;
            end else if (cur.st == M_DEC) begin
                if (d == 0 || cur.lvl - d <= tgt) begin
                    n.lvl = tgt; n.st = M_SUS;
                end else n.lvl = cur.lvl - d;
            end else if (cur.st == M_SUS) begin
                n.lvl = tgt;
            end else if (cur.st == M_REL) begin
`ifdef ENV_EXP_RELEASE_EN
                dec = (cur.lvl >> (r % 16)) + 1;
`else
                dec = r;
`endif
                if (r == 0 || cur.lvl - dec <= 0) begin
                    n.lvl = 0; n.st = M_IDLE;
                end else n.lvl = cur.lvl - dec;
            end
        end
        return n;
    endfunction

    // Model update on the same edges and resets as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_env  <= '{M_IDLE, 0};
            m_cnt  <= 0;
            m_gq   <= 1'b0;
            m_prod <= 0;
            m_vout <= MID;
        end else begin
            m_env  <= env_next(m_env, m_cnt == TICK_DIV - 1, gate, m_gq,
                               int'(attack_step), int'(decay_step),
                               int'(sustain_level), int'(release_rate));
            m_cnt  <= (m_cnt + 1) % TICK_DIV;
            m_gq   <= gate;
            m_prod <= (int'(v_in) - MID) * (m_env.lvl / 256);
            m_vout <= MID + fdiv256(m_prod);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            total++;
            if (int'(env_level) != m_env.lvl) begin
                bad++;
                $display("FAIL model_level t=%0t: got 0x%0h want 0x%0h", $time, env_level, m_env.lvl);
            end
            total++;
            if (busy != (m_env.st != M_IDLE)) begin
                bad++;
                $display("FAIL model_busy t=%0t: got %0d want %0d", $time, busy, m_env.st != M_IDLE);
            end
            total++;
            if (int'(v_out) != m_vout) begin
                bad++;
                $display("FAIL model_vout t=%0t: got %0d want %0d", $time, v_out, m_vout);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Advance to the falling edge just after the next tick edge. The posedge
    // that follows it is the first cycle of a tick period, so it is not a tick.
    task automatic next_period();
        @(negedge clk);
        while (m_cnt != 0) @(negedge clk);
    endtask

    // Advance to the falling edge just before a tick edge.
    task automatic to_tick_eve();
        @(negedge clk);
        while (m_cnt != TICK_DIV - 1) @(negedge clk);
    endtask

    task automatic busy_within_2(string name);
        int n;
        n = 0;
        while (!busy && n < 2) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1);
    endtask

    typedef struct {
        int vin;
        int vexp;
    } vca_vec_t;

    vca_vec_t vtab[8];

    // ---------------- stimulus ----------------
    initial begin
        int prev;
        int n;
        int steps_ok;
        int changes;

        vtab[0] = '{4095, 4087};
        vtab[1] = '{0,    8};
        vtab[2] = '{2048, 2048};
        vtab[3] = '{2049, 2048};
        vtab[4] = '{2047, 2047};
        vtab[5] = '{3072, 3068};
        vtab[6] = '{1024, 1028};
        vtab[7] = '{1,    8};

        // Reset held with the gate high.
        rst_n = 1'b0;
        gate  = 1'b1;
        repeat (3) @(negedge clk);
        m_on = 1'b1;
        chk("rst_level", env_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vout", v_out, 2048);
        #1 rst_n = 1'b1;
        busy_within_2("rst_busy_within_2clk");
        gate = 1'b0;
        next_period();
        next_period();
        next_period();
        chk("rst_back_idle", busy, 0);

        // Attack 0x80 per tick, clamp, then decay 0x40 per tick to 0x8080.
        attack_step   = 8'h80;
        decay_step    = 8'h40;
        sustain_level = 8'h80;
        release_rate  = 8'h00;
        next_period();
        gate     = 1'b1;
        prev     = 0;
        steps_ok = 1;
        n        = 0;
        while (env_level != 16'hFFFF && n < 4 * 600) begin
            @(negedge clk);
            n++;
            if (env_level != 16'hFFFF) begin
                if (int'(env_level) != prev && int'(env_level) != prev + 'h80) steps_ok = 0;
                prev = int'(env_level);
            end
        end
        chk("att_reach_ffff", env_level, 'hFFFF);
        chk("att_last_before_clamp", prev, 'hFF80);
        chk("att_step_0x80", steps_ok, 1);
        changes = 0;
        prev    = int'(env_level);
        n       = 0;
        while (env_level != 16'h8080 && n < 4 * 600) begin
            @(negedge clk);
            n++;
            if (int'(env_level) != prev) changes++;
            prev = int'(env_level);
        end
        chk("dec_reach_8080", env_level, 'h8080);
        chk("dec_tick_count", changes, 510);
        repeat (10) next_period();
        chk("sus_hold_8080", env_level, 'h8080);
        chk("sus_busy", busy, 1);
        next_period();
        gate = 1'b0;
        next_period();
        chk("rel_instant_level", env_level, 0);
        chk("rel_instant_idle", busy, 0);

        // Instant steps everywhere.
        attack_step = 8'h00;
        decay_step  = 8'h00;
        next_period();
        gate = 1'b1;
        next_period();
        chk("inst_attack", env_level, 'hFFFF);
        next_period();
        chk("inst_decay", env_level, 'h8080);
        next_period();
        gate = 1'b0;
        next_period();
        chk("inst_release_level", env_level, 0);
        chk("inst_release_idle", busy, 0);

        // Retrigger from a partly released level.
        sustain_level = 8'hC0;
        release_rate  = 8'h40;
        next_period();
        gate = 1'b1;
        next_period();
        next_period();
        chk("retrig_sustain", env_level, 'hC0C0);
        next_period();
        gate = 1'b0;
        repeat (3) next_period();
        chk("retrig_released3", env_level, 'hC000);
        attack_step = 8'h10;
        gate        = 1'b1;
        @(negedge clk);
        chk("retrig_no_jump", env_level, 'hC000);
        chk("retrig_busy", busy, 1);
        next_period();
        chk("retrig_attack_from_level", env_level, 'hC010);
        attack_step   = 8'h00;
        sustain_level = 8'h80;
        next_period();
        next_period();
        chk("retrig_resettle", env_level, 'h8080);

        // Gate fall on a tick cycle: the state change wins and the level holds.
        to_tick_eve();
        gate          = 1'b0;
        sustain_level = 8'h90;
        @(negedge clk);
        chk("simul_level_held", env_level, 'h8080);
        next_period();
        chk("simul_then_release", env_level, 'h8040);
        release_rate = 8'h00;
        next_period();
        chk("simul_idle", busy, 0);

        // VCA at full level, applied as a table.
        sustain_level = 8'hFF;
        next_period();
        gate = 1'b1;
        next_period();
        next_period();
        chk("vca_level_ffff", env_level, 'hFFFF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v_in = DEPTH'(vtab[i].vin);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("vca_vin_%0d", vtab[i].vin), v_out, vtab[i].vexp);
        end
        next_period();
        gate = 1'b0;
        next_period();
        @(negedge clk);
        v_in = 12'd4095;
        @(negedge clk);
        @(negedge clk);
        chk("vca_level0", v_out, 2048);

        // Asynchronous reset in mid-attack.
        attack_step = 8'h10;
        next_period();
        gate = 1'b1;
        next_period();
        next_period();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_level", env_level, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_vout", v_out, 2048);
        #1 rst_n = 1'b1;
        busy_within_2("async_rst_regate");
        attack_step = 8'h00;
        gate        = 1'b0;
        next_period();
        next_period();

        // Randomised run against the model.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            v_in = DEPTH'($urandom_range(0, 4095));
            if ($urandom_range(0, 59) == 0) gate = ~gate;
            if ($urandom_range(0, 31) == 0) attack_step   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 31) == 0) decay_step    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 31) == 0) sustain_level = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 31) == 0) release_rate  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        m_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
